// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one synchronous single-port character RAM between the
// VGA character fetch (one reserved slot per 16-pixel cell) and the CPU bus
// (level request, one-cycle ack). All RAM port signals are registered, so the
// grant is decided one cycle before the access appears on the port.
module vram_arbiter #(
    parameter int AW       = 11,
    parameter int DW       = 8,
    parameter int VGA_SLOT = 13
) (
    input  logic          clk_pxl,
    input  logic          rst_n,
    input  logic [3:0]    pix_phase,
    input  logic          vga_active,
    input  logic [AW-1:0] vga_a,
    output logic [DW-1:0] vga_d,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_a,
    input  logic [DW-1:0] cpu_wd,
    output logic [DW-1:0] cpu_rd,
    output logic          cpu_ack,
    output logic          cpu_wait,
    output logic [AW-1:0] ram_a,
    output logic          ram_we,
    output logic [DW-1:0] ram_wd,
    input  logic [DW-1:0] ram_rd
);

    // Phase in which the VGA slot for the following cycle is claimed.
    localparam logic [3:0] RES_PHASE = 4'(VGA_SLOT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DATA, ACK} state_t;

    state_t        state_reg;
    state_t        state_next;
    logic          reserve;
    logic          cpu_grant;
    logic          vga_issue_reg;
    logic          vga_capture_reg;
    logic [DW-1:0] stage_reg;

    // The VGA claim always wins; the CPU only loses the one cycle before the slot.
    assign reserve   = vga_active && (pix_phase == RES_PHASE);
    assign cpu_grant = (state_reg == IDLE) && cpu_req && !reserve;
    assign cpu_ack   = (state_reg == ACK);
    assign cpu_wait  = cpu_req & ~cpu_ack;

    // CPU FSM state register.
    always_ff @(posedge clk_pxl or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // CPU FSM next state; ram_we holds the registered copy of the access type during ISSUE.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (cpu_grant) state_next = ISSUE;
            ISSUE:   state_next = ram_we ? ACK : DATA;
            DATA:    state_next = ACK;
            ACK:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // RAM port: load the granted access for the next cycle; write enable is a single-cycle pulse.
    always_ff @(posedge clk_pxl or negedge rst_n) begin
        if (!rst_n) begin
            ram_a  <= '0;
            ram_we <= 1'b0;
            ram_wd <= '0;
        end else begin
            ram_we <= 1'b0;
            if (reserve) begin
                ram_a <= vga_a;
            end else if (cpu_grant) begin
                ram_a  <= cpu_a;
                ram_we <= cpu_we;
                ram_wd <= cpu_wd;
            end
        end
    end

    // VGA pipeline: issue flag, capture flag, staging register and cell-boundary transfer.
    always_ff @(posedge clk_pxl or negedge rst_n) begin
        if (!rst_n) begin
            vga_issue_reg   <= 1'b0;
            vga_capture_reg <= 1'b0;
            stage_reg       <= '0;
            vga_d           <= '0;
        end else begin
            vga_issue_reg   <= reserve;
            vga_capture_reg <= vga_issue_reg;
            if (vga_capture_reg) begin
                stage_reg <= ram_rd;
            end
            // Without a fresh fetch the staging register still equals vga_d, so vga_d holds.
            if (pix_phase == 4'd15) begin
                vga_d <= stage_reg;
            end
        end
    end

    // CPU read data: captured in the DATA cycle and held until the next read.
    always_ff @(posedge clk_pxl or negedge rst_n) begin
        if (!rst_n) begin
            cpu_rd <= '0;
        end else if (state_reg == DATA) begin
            cpu_rd <= ram_rd;
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// Testbench for vram_arbiter: directed scenarios with a RAM model; expected
// RAM issues, acks and vga_d values are queued by absolute cycle number and
// checked by an independent monitor.
module tb_vram_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  pix_phase;
    logic        vga_active;
    logic [10:0] vga_a;
    logic [7:0]  vga_d;
    logic        cpu_req;
    logic        cpu_we;
    logic [10:0] cpu_a;
    logic [7:0]  cpu_wd;
    logic [7:0]  cpu_rd;
    logic        cpu_ack;
    logic        cpu_wait;
    logic [10:0] ram_a;
    logic        ram_we;
    logic [7:0]  ram_wd;
    logic [7:0]  ram_rd;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {int cyc; logic [10:0] a; logic we; logic [7:0] wd;} issue_t;
    typedef struct {int cyc; logic rd_chk; logic [7:0] rd;} ack_t;
    typedef struct {int cyc; logic [7:0] d;} vga_t;

    issue_t iq[$];
    ack_t   aq[$];
    vga_t   vq[$];

    logic [7:0] mem [0:2047];

    vram_arbiter dut (
        .clk_pxl    (clk),
        .rst_n      (rst_n),
        .pix_phase  (pix_phase),
        .vga_active (vga_active),
        .vga_a      (vga_a),
        .vga_d      (vga_d),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_a      (cpu_a),
        .cpu_wd     (cpu_wd),
        .cpu_rd     (cpu_rd),
        .cpu_ack    (cpu_ack),
        .cpu_wait   (cpu_wait),
        .ram_a      (ram_a),
        .ram_we     (ram_we),
        .ram_wd     (ram_wd),
        .ram_rd     (ram_rd)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Free-running horizontal counter; its low nibble is the pixel phase.
    always @(posedge clk) cyc <= cyc + 1;
    assign pix_phase = cyc[3:0];

    // Synchronous RAM model, read-before-write.
    always @(posedge clk) begin
        if (ram_we) mem[ram_a] <= ram_wd;
        ram_rd <= mem[ram_a];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end else begin
            $display("ok   %s = 0x%0h (cycle %0d)", name, act, cyc);
        end
    endtask

    // Advance to the start of the next cycle whose phase is p.
    task automatic goto_phase(input int p);
        do begin
            @(posedge clk);
            #1;
        end while (pix_phase != 4'(p));
    endtask

    // Start a CPU access in the current cycle; blk = cycles the grant is blocked.
    task automatic cpu_start(input logic we, input logic [10:0] a, input logic [7:0] wd,
                             input logic [7:0] rd, input int blk);
        int d;
        d = cyc + blk;
        cpu_req = 1'b1;
        cpu_we  = we;
        cpu_a   = a;
        cpu_wd  = wd;
        iq.push_back(issue_t'{d + 1, a, we, wd});
        aq.push_back(ack_t'{(we ? d + 2 : d + 3), !we, rd});
    endtask

    // Wait (bounded) for the ack, checking WAIT meanwhile, then drop the request in the ACK cycle.
    task automatic cpu_finish();
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (cpu_ack) break;
            chk("cpu_wait_high", cpu_wait, 1);
        end
        cpu_req = 1'b0;
    endtask

    // Monitor: compares RAM issues, acks and vga_d against the queued expectations.
    initial begin
        issue_t     ei;
        ack_t       ea;
        vga_t       ev;
        logic [7:0] vga_prev;
        vga_prev = 8'h00;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                while (iq.size() > 0 && iq[0].cyc < cyc) begin
                    ei = iq.pop_front();
                    chk("issue_missed_addr", ram_a, ei.a);
                end
                if (iq.size() > 0 && iq[0].cyc == cyc) begin
                    ei = iq.pop_front();
                    chk("issue_addr", ram_a, ei.a);
                    chk("issue_we", ram_we, ei.we);
                    if (ei.we) chk("issue_wd", ram_wd, ei.wd);
                end else if (ram_we) begin
                    chk("stray_write", ram_we, 0);
                end

                if (cpu_ack) begin
                    if (aq.size() == 0) begin
                        chk("stray_ack", cpu_ack, 0);
                    end else begin
                        ea = aq.pop_front();
                        chk("ack_cycle", cyc, ea.cyc);
                        if (ea.rd_chk) chk("cpu_rd", cpu_rd, ea.rd);
                        chk("cpu_wait_at_ack", cpu_wait, 0);
                    end
                end else if (aq.size() > 0 && aq[0].cyc < cyc) begin
                    ea = aq.pop_front();
                    chk("ack_missing", cpu_ack, 1);
                end

                if (vq.size() > 0 && vq[0].cyc == cyc) begin
                    ev = vq.pop_front();
                    chk("vga_d", vga_d, ev.d);
                end
                if (vga_d !== vga_prev) chk("vga_d_change_phase", pix_phase, 0);
                vga_prev = vga_d;
            end
        end
    end

    initial begin
        int r;
        int d;
        int n;
        for (int i = 0; i < 2048; i++) mem[i] = 8'h00;
        mem[11'h123] = 8'h33;
        mem[11'h045] = 8'h41;
        mem[11'h046] = 8'h42;
        mem[11'h010] = 8'h99;
        mem[11'h020] = 8'h11;
        ram_rd     = 8'h00;
        rst_n      = 1'b0;
        cpu_req    = 1'b0;
        cpu_we     = 1'b0;
        cpu_a      = '0;
        cpu_wd     = '0;
        vga_active = 1'b0;
        vga_a      = '0;

        // Reset values.
        repeat (3) @(negedge clk);
        chk("rst_ram_a", ram_a, 0);
        chk("rst_ram_we", ram_we, 0);
        chk("rst_ram_wd", ram_wd, 0);
        chk("rst_vga_d", vga_d, 0);
        chk("rst_cpu_rd", cpu_rd, 0);
        chk("rst_cpu_ack", cpu_ack, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Reset in the middle of a write: the write must be dropped.
        goto_phase(2);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_a = 11'h123; cpu_wd = 8'hAA;
        @(posedge clk); #1;
        chk("inflight_we", ram_we, 1);
        chk("inflight_a", ram_a, 11'h123);
        rst_n = 1'b0;
        cpu_req = 1'b0;
        #1;
        chk("abort_ram_we", ram_we, 0);
        chk("abort_ram_a", ram_a, 0);
        chk("abort_ram_wd", ram_wd, 0);
        chk("abort_cpu_ack", cpu_ack, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        goto_phase(5);
        cpu_start(1'b0, 11'h123, 8'h00, 8'h33, 0);
        cpu_finish();

        // Idle VGA fetch of 0x045.
        goto_phase(11);
        vga_active = 1'b1; vga_a = 11'h045;
        r = cyc + 1;
        iq.push_back(issue_t'{r + 1, 11'h045, 1'b0, 8'h00});
        vq.push_back(vga_t'{r + 4, 8'h41});
        goto_phase(13);
        vga_active = 1'b0;

        // CPU write then read-back of 0x7FF with the display idle.
        goto_phase(3);
        cpu_start(1'b1, 11'h7FF, 8'h5A, 8'h00, 0);
        cpu_finish();
        goto_phase(7);
        cpu_start(1'b0, 11'h7FF, 8'h00, 8'h5A, 0);
        cpu_finish();

        // Collision: CPU read requested in the reservation cycle is pushed back one cycle.
        goto_phase(11);
        vga_active = 1'b1; vga_a = 11'h046;
        goto_phase(12);
        r = cyc;
        iq.push_back(issue_t'{r + 1, 11'h046, 1'b0, 8'h00});
        cpu_start(1'b0, 11'h010, 8'h00, 8'h99, 1);
        vq.push_back(vga_t'{r + 4, 8'h42});
        @(posedge clk); #1;
        vga_active = 1'b0;
        cpu_finish();

        // Back-to-back: request held through the first ack starts a second write.
        goto_phase(2);
        d = cyc;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_a = 11'h030; cpu_wd = 8'h01;
        iq.push_back(issue_t'{d + 1, 11'h030, 1'b1, 8'h01});
        aq.push_back(ack_t'{d + 2, 1'b0, 8'h00});
        iq.push_back(issue_t'{d + 4, 11'h030, 1'b1, 8'h01});
        aq.push_back(ack_t'{d + 5, 1'b0, 8'h00});
        n = 0;
        for (int i = 0; i < 20 && n < 2; i++) begin
            @(negedge clk);
            if (cpu_ack) n++;
        end
        cpu_req = 1'b0;

        // Write-through: CPU updates the character the VGA fetches in the same cell.
        goto_phase(5);
        vga_active = 1'b1; vga_a = 11'h020;
        cpu_start(1'b1, 11'h020, 8'h7E, 8'h00, 0);
        cpu_finish();
        goto_phase(12);
        r = cyc;
        iq.push_back(issue_t'{r + 1, 11'h020, 1'b0, 8'h00});
        vq.push_back(vga_t'{r + 4, 8'h7E});
        goto_phase(13);
        vga_active = 1'b0;

        // Drain and confirm every expectation was consumed.
        repeat (20) @(posedge clk);
        #1;
        chk("issue_queue_empty", iq.size(), 0);
        chk("ack_queue_empty", aq.size(), 0);
        chk("vga_queue_empty", vq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
